// File: rtl/maxpool_win_sched.sv
// rtl/maxpool_win_sched.sv - 2x2/stride-2 max-pool window sequencer over a CxHxW map
// Reads each window from a 1-cycle-latency buffer and streams its signed maximum downstream.
module maxpool_win_sched #(
  parameter int WIDTH_IN  = 8,
  parameter int HEIGHT_IN = 8,
  parameter int CHANNELS  = 64,
  parameter int POOL_SIZE = 2,
  parameter int STRIDE    = 2,
  parameter int DATA_W    = 25,
  parameter int IN_AW     = 12,
  parameter int OUT_AW    = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              rd_en,
  output logic [IN_AW-1:0]  rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [OUT_AW-1:0] out_addr,
  output logic [DATA_W-1:0] out_data
);

  localparam int WIDTH_OUT  = (WIDTH_IN - POOL_SIZE) / STRIDE + 1;
  localparam int HEIGHT_OUT = (HEIGHT_IN - POOL_SIZE) / STRIDE + 1;
  localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int HW = (HEIGHT_OUT > 1) ? $clog2(HEIGHT_OUT) : 1;
  localparam int WW = (WIDTH_OUT > 1) ? $clog2(WIDTH_OUT) : 1;
  localparam int PW = (POOL_SIZE > 1) ? $clog2(POOL_SIZE) : 1;
  localparam logic [CW-1:0] C_LAST  = CW'(CHANNELS - 1);
  localparam logic [HW-1:0] PH_LAST = HW'(HEIGHT_OUT - 1);
  localparam logic [WW-1:0] PW_LAST = WW'(WIDTH_OUT - 1);
  localparam logic [PW-1:0] E_LAST  = PW'(POOL_SIZE - 1);

  typedef enum logic [2:0] {IDLE, RD, LAST, OUT, DONE} state_t;

  state_t            state;
  logic [CW-1:0]     c, c_n;
  logic [HW-1:0]     ph, ph_n;
  logic [WW-1:0]     pw, pw_n;
  logic [PW-1:0]     i, j, i_n, j_n;
  logic              last_win, last_elem;
  logic              rd_en_d, first_d, take;
  logic [DATA_W-1:0] max_r, max_nx;

  function automatic logic [IN_AW-1:0] in_addr(int cc, int pph, int ppw, int ii, int jj);
    int a;
    a = cc * WIDTH_IN * HEIGHT_IN + (pph * STRIDE + ii) * WIDTH_IN + ppw * STRIDE + jj;
    return IN_AW'(a);
  endfunction

  function automatic logic [OUT_AW-1:0] pool_addr(int cc, int pph, int ppw);
    int a;
    a = cc * WIDTH_OUT * HEIGHT_OUT + pph * WIDTH_OUT + ppw;
    return OUT_AW'(a);
  endfunction

  always_comb begin
    c_n = c;
    ph_n = ph;
    pw_n = pw;
    i_n = i;
    j_n = j;
    last_win  = (c == C_LAST) && (ph == PH_LAST) && (pw == PW_LAST);
    last_elem = (i == E_LAST) && (j == E_LAST);
    if (pw == PW_LAST) begin
      pw_n = '0;
      if (ph == PH_LAST) begin
        ph_n = '0;
        c_n  = c + CW'(1);
      end else begin
        ph_n = ph + HW'(1);
      end
    end else begin
      pw_n = pw + WW'(1);
    end
    if (j == E_LAST) begin
      j_n = '0;
      i_n = i + PW'(1);
    end else begin
      j_n = j + PW'(1);
    end
  end

  // First element of a window loads unconditionally; later ones replace only on strict greater.
  always_comb begin
    take   = rd_en_d && (first_d || ($signed(rd_data) > $signed(max_r)));
    max_nx = take ? rd_data : max_r;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      c         <= '0;
      ph        <= '0;
      pw        <= '0;
      i         <= '0;
      j         <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      rd_en     <= 1'b0;
      rd_addr   <= '0;
      out_valid <= 1'b0;
      out_addr  <= '0;
      out_data  <= '0;
      rd_en_d   <= 1'b0;
      first_d   <= 1'b0;
      max_r     <= '0;
    end else begin
      done    <= 1'b0;
      rd_en_d <= rd_en;
      first_d <= rd_en && (i == '0) && (j == '0);
      max_r   <= max_nx;
      case (state)
        IDLE: begin
          if (start) begin
            state   <= RD;
            busy    <= 1'b1;
            c       <= '0;
            ph      <= '0;
            pw      <= '0;
            i       <= '0;
            j       <= '0;
            rd_en   <= 1'b1;
            rd_addr <= in_addr(0, 0, 0, 0, 0);
          end
        end
        RD: begin
          if (last_elem) begin
            i     <= '0;
            j     <= '0;
            rd_en <= 1'b0;
            state <= LAST;
          end else begin
            i       <= i_n;
            j       <= j_n;
            rd_addr <= in_addr(int'(c), int'(ph), int'(pw), int'(i_n), int'(j_n));
          end
        end
        LAST: begin
          out_valid <= 1'b1;
          out_data  <= max_nx;
          out_addr  <= pool_addr(int'(c), int'(ph), int'(pw));
          state     <= OUT;
        end
        OUT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            if (last_win) begin
              done  <= 1'b1;
              state <= DONE;
            end else begin
              c       <= c_n;
              ph      <= ph_n;
              pw      <= pw_n;
              rd_en   <= 1'b1;
              rd_addr <= in_addr(int'(c_n), int'(ph_n), int'(pw_n), 0, 0);
              state   <= RD;
            end
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_maxpool_win_sched.sv
// tb/tb_maxpool_win_sched.sv - scoreboard bench for maxpool_win_sched
module tb_maxpool_win_sched;
  localparam int DW = 25;
  localparam int IAW = 12;
  localparam int OAW = 10;
  localparam int NWIN = 1024;

  logic           clk = 1'b0;
  logic           rst;
  logic           start;
  logic           busy, done, rd_en, out_valid;
  logic           out_ready = 1'b1;
  logic [IAW-1:0] rd_addr;
  logic [DW-1:0]  rd_data;
  logic [OAW-1:0] out_addr;
  logic [DW-1:0]  out_data;

  always #5 clk = ~clk;

  maxpool_win_sched dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_addr(out_addr), .out_data(out_data)
  );

  int mem[4096];
  int exp_addr[$];
  int exp_data[$];
  int n_pass = 0, n_checks = 0;
  int n_out = 0, done_cnt = 0, done_cyc = 0, cyc_cnt = 0, ready_mode = 0;
  logic           stall_prev = 1'b0;
  logic [OAW-1:0] st_addr;
  logic [DW-1:0]  st_data;

  task automatic chk(string name, longint act, longint exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // Input buffer: 1-cycle read latency, junk on cycles without a read.
  always @(posedge clk) begin
    cyc_cnt <= cyc_cnt + 1;
    rd_data <= rd_en ? DW'(mem[rd_addr]) : DW'($urandom);
  end

  always @(posedge clk) begin
    #1;
    case (ready_mode)
      0: out_ready = 1'b1;
      1: out_ready = ($urandom_range(0, 99) >= 40);
      default: out_ready = !(out_valid && out_addr == OAW'(500));
    endcase
  end

  always @(negedge clk) begin
    if (!rst) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev && out_valid) begin
        chk("stall_addr_hold", out_addr, st_addr);
        chk("stall_data_hold", $signed(out_data), $signed(st_data));
      end
      if (out_valid && !out_ready) chk("no_rd_in_stall", rd_en, 0);
      if (out_valid && out_ready) begin
        if (exp_addr.size() == 0) begin
          chk("unexpected_output", 1, 0);
        end else begin
          chk("out_addr", out_addr, exp_addr.pop_front());
          chk("out_data", $signed(out_data), exp_data.pop_front());
        end
        n_out++;
      end
      stall_prev = out_valid && !out_ready;
      st_addr = out_addr;
      st_data = out_data;
      if (done) begin
        done_cnt++;
        done_cyc = cyc_cnt;
      end
    end
  end

  task automatic load_golden();
    exp_addr.delete();
    exp_data.delete();
    for (int c = 0; c < 64; c++)
      for (int ph = 0; ph < 4; ph++)
        for (int pw = 0; pw < 4; pw++) begin
          int base, m, v;
          base = c * 64 + ph * 16 + pw * 2;
          m = mem[base];
          for (int k = 1; k < 4; k++) begin
            v = mem[base + (k / 2) * 8 + (k % 2)];
            if (v > m) m = v;
          end
          exp_addr.push_back(c * 16 + ph * 4 + pw);
          exp_data.push_back(m);
        end
  endtask

  task automatic load_ramp_expect();
    exp_addr.delete();
    exp_data.delete();
    for (int c = 0; c < 64; c++)
      for (int ph = 0; ph < 4; ph++)
        for (int pw = 0; pw < 4; pw++) begin
          exp_addr.push_back(c * 16 + ph * 4 + pw);
          exp_data.push_back(c * 64 + (2 * ph + 1) * 8 + 2 * pw + 1);
        end
  endtask

  task automatic run_map(string tag, int budget, bit chk_timing, int poke_at);
    int  e0;
    bit  poked;
    poked = 1'b0;
    done_cnt = 0;
    n_out = 0;
    @(negedge clk);
    e0 = cyc_cnt;
    start = 1'b1;
    for (int k = 0; k < budget && done_cnt == 0; k++) begin
      @(negedge clk);
      start = 1'b0;
      if (poke_at >= 0 && !poked && n_out >= poke_at) begin
        start = 1'b1;
        poked = 1'b1;
      end
    end
    start = 1'b0;
    repeat (4) @(negedge clk);
    chk({tag, "_done_count"}, done_cnt, 1);
    chk({tag, "_outputs"}, n_out, NWIN);
    chk({tag, "_sb_empty"}, exp_addr.size(), 0);
    chk({tag, "_busy_after"}, busy, 0);
    if (chk_timing) chk({tag, "_done_cycle"}, done_cyc - e0, 6145);
  endtask

  initial begin
    bit found;
    rst = 1'b0;
    start = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_rd_en", rd_en, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_rd_addr", rd_addr, 0);
    chk("rst_out_addr", out_addr, 0);
    chk("rst_out_data", out_data, 0);
    rst = 1'b1;
    @(negedge clk);
    chk("idle_busy", busy, 0);

    for (int k = 0; k < 4096; k++) mem[k] = k;
    load_ramp_expect();
    run_map("ramp", 8000, 1'b1, -1);

    // Hand-computed windows in channel 0 row 0; everything else stays ramp.
    mem[0] = -5;  mem[1] = -3;  mem[8] = -3;  mem[9] = -9;
    mem[2] = -16777216; mem[3] = -16777216; mem[10] = -16777216; mem[11] = -16777216;
    mem[4] = 7;   mem[5] = 7;   mem[12] = 2;  mem[13] = 7;
    mem[6] = -1;  mem[7] = -2;  mem[14] = -3; mem[15] = 100;
    load_ramp_expect();
    exp_data[0] = -3;
    exp_data[1] = -16777216;
    exp_data[2] = 7;
    exp_data[3] = 100;
    run_map("signed", 8000, 1'b0, -1);

    for (int k = 0; k < 4096; k++) mem[k] = int'($urandom) >>> 7;
    load_golden();
    ready_mode = 1;
    run_map("random", 30000, 1'b0, 100);
    ready_mode = 0;

    for (int k = 0; k < 4096; k++) mem[k] = int'($urandom) >>> 7;
    load_golden();
    ready_mode = 2;
    done_cnt = 0;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    found = 1'b0;
    for (int k = 0; k < 10000 && !found; k++) begin
      @(negedge clk);
      if (out_valid && out_addr == OAW'(500)) found = 1'b1;
    end
    chk("reach_win500", found, 1);
    repeat (3) @(negedge clk);
    chk("win500_stalled", out_valid, 1);
    rst = 1'b0;
    #1;
    chk("abort_out_valid", out_valid, 0);
    chk("abort_busy", busy, 0);
    chk("abort_rd_en", rd_en, 0);
    chk("abort_out_addr", out_addr, 0);
    exp_addr.delete();
    exp_data.delete();
    repeat (2) @(negedge clk);
    rst = 1'b1;
    ready_mode = 0;
    repeat (2) @(negedge clk);
    chk("abort_no_done", done_cnt, 0);
    load_golden();
    run_map("rerun", 8000, 1'b1, -1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/maxpool_win_sched.md
Name: maxpool_win_sched

Overview:
Sequencer for the 2x2/stride-2 max-pool stage that follows conv layer 3. It walks every pooling window of a CHANNELS x HEIGHT_IN x WIDTH_IN signed Q15 feature-map buffer, issuing reads to a synchronous buffer with 1-cycle read latency. It reduces each window to its signed maximum and delivers each pooled value, with its output address, on a valid/ready stream to the pooled-map buffer. One start request processes the whole map.

Parameters:
WIDTH_IN, 8, input map width
HEIGHT_IN, 8, input map height
CHANNELS, 64, channel count
POOL_SIZE, 2, window edge
STRIDE, 2, window step
DATA_W, 25, signed sample width (Q15 post-conv integers)
IN_AW, 12, input address width (>= clog2(CHANNELS*WIDTH_IN*HEIGHT_IN))
OUT_AW, 10, output address width (>= clog2(CHANNELS*WIDTH_OUT*HEIGHT_OUT))
Derived: WIDTH_OUT=(WIDTH_IN-POOL_SIZE)/STRIDE+1; HEIGHT_OUT likewise (4 and 4 at defaults)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-low reset
start  in  1  start request, sampled only in IDLE
busy  out  1  high in every state except IDLE
done  out  1  one-cycle pulse after the last window is accepted
rd_en  out  1  input-buffer read strobe
rd_addr  out  IN_AW  input address = c*W*H + row*WIDTH_IN + col
rd_data  in  DATA_W  signed, valid the cycle after rd_en
out_valid  out  1  pooled result valid
out_ready  in  1  downstream accept
out_addr  out  OUT_AW  = c*WIDTH_OUT*HEIGHT_OUT + ph*WIDTH_OUT + pw
out_data  out  DATA_W  signed window maximum

Behaviour:
- Reset (rst=0, asynchronous): state IDLE; all counters 0; busy, done, rd_en, out_valid = 0; rd_addr, out_addr, out_data = 0.
- All outputs are registered. Counters: c (outer), ph, pw (inner), i, j (window row/col).
- Window order is channel-major, then ph, then pw. Element order inside a window is row-major: (0,0),(0,1),(1,0),(1,1).
- row = ph*STRIDE+i; col = pw*STRIDE+j.
- States:
  - IDLE: start=1 -> RD, with all counters cleared.
  - RD: rd_en=1 for POOL_SIZE^2 consecutive cycles, one element per cycle. After the last issue -> LAST.
  - LAST: one cycle to capture the final rd_data -> OUT.
  - OUT: out_valid=1; out_addr and out_data are held stable until out_valid & out_ready.
    - On handshake, if the last window (c=CHANNELS-1, ph=HEIGHT_OUT-1, pw=WIDTH_OUT-1) -> DONE.
    - Otherwise advance pw/ph/c with wrap and go to RD on the next cycle.
  - DONE: done=1 for exactly one cycle -> IDLE. busy stays 1 in DONE and goes 0 in IDLE.
- Reduction: the first element of a window loads max_r directly, with no sentinel. Each later element replaces max_r only if strictly greater under signed DATA_W compare, so ties keep the earlier value. No saturation or truncation: out_data is the exact input value.
- Timing with out_ready held high: start is sampled at edge E0. RD occupies cycles 1-4, LAST cycle 5, OUT cycle 6. That is 6 cycles per window, 1024 windows = 6144 cycles at defaults. done asserts in cycle 6145.
- Backpressure: OUT waits indefinitely; no reads are issued while out_valid=1 and out_ready=0.
- start while busy: ignored, no restart, no effect on counters.
- start held high across DONE: a new run begins on the first IDLE cycle in which start is sampled high.
- rd_data is ignored in any cycle not following an rd_en.
- Reset mid-operation: immediate abort to IDLE. No done pulse; out_valid drops asynchronously.

Test Plan:
- Ramp map (value = flat input index), out_ready=1 -> 1024 outputs in order. out_addr 0..1023 sequential, and out_data = c*64+(2ph+1)*8+2pw+1. done pulses once at cycle 6145.
- Window {-5, -3, -3, -9}, and a window of all -16777216 -> out_data -3 and -16777216. Confirms the signed compare and that no sentinel is used.
- Tie window {7, 7, 2, 7} -> out_data 7, the value loaded from element (0,0).
- Random map with out_ready toggled pseudo-randomly (about 40% low) -> out_data/out_addr stable while stalled and no rd_en during a stall. Results match the golden model; total outputs = 1024.
- start pulsed at window 100 while busy -> no restart, output sequence unaffected, single done.
- rst driven low during window 500 OUT stall, then start reissued -> outputs clear immediately, no done. The second run restarts at out_addr 0 and completes all 1024 windows.
